// File: rtl/mips_mem_responder_pkg.sv
// Shared definitions for the MIPS memory responder: MMIO map, default window base
// and the address-region decode used by the top and its register block.
package mips_mem_responder_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FFF0;

   localparam logic [1:0] MMIO_LED    = 2'd0;
   localparam logic [1:0] MMIO_SW     = 2'd1;
   localparam logic [1:0] MMIO_CYCLE  = 2'd2;
   localparam logic [1:0] MMIO_STATUS = 2'd3;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_MMIO,
      REGION_ILLEGAL
   } regionT;

   // Offset test is done after subtraction so a window placed at the very top
   // of the address space cannot overflow base+3.
   function automatic regionT decodeRegion(input logic [31:0] addr,
                                           input logic [31:0] depth,
                                           input logic [31:0] base);
      regionT r;
      logic [31:0] off;
      off = addr - base;
      if (addr < depth)
         r = REGION_RAM;
      else if (addr >= base && off < 32'd4)
         r = REGION_MMIO;
      else
         r = REGION_ILLEGAL;
      return r;
   endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Core-to-memory request signals: chip select, write enable and word address.
// The shared data bus is a separate inout net because it is resolved across blocks.
interface mips_mem_responder_if;
   logic        CS;
   logic        WE;
   logic [31:0] Address;

   modport master (output CS, WE, Address);
   modport slave  (input  CS, WE, Address);
endinterface

// File: rtl/mips_mem_responder_mmio_regs.sv
// LED, free-running CYCLE and sticky STATUS registers plus their read mux.
// Writes land at posedge; reads are combinational and registered by the top at negedge.
module mips_mmio_regs
   import mips_mem_responder_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        wrEn,
   input  logic        errSet,
   input  logic [1:0]  offset,
   input  logic [7:0]  wrData,
   input  logic [7:0]  SW,
   output logic [7:0]  LED,
   output logic        Mem_Err,
   output logic [31:0] rdData
);

   logic [31:0] cycleCnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         LED      <= '0;
         cycleCnt <= '0;
         Mem_Err  <= 1'b0;
      end else begin
         cycleCnt <= cycleCnt + 32'd1;
         if (wrEn && offset == MMIO_LED)
            LED <= wrData;
         // A new illegal access outranks a simultaneous clear.
         if (errSet)
            Mem_Err <= 1'b1;
         else if (wrEn && offset == MMIO_STATUS && wrData[0])
            Mem_Err <= 1'b0;
      end
   end

   always_comb begin
      rdData = '0;
      case (offset)
         MMIO_LED:    rdData = {24'h0, LED};
         MMIO_SW:     rdData = {24'h0, SW};
         MMIO_CYCLE:  rdData = cycleCnt;
         MMIO_STATUS: rdData = {31'h0, Mem_Err};
         default:     rdData = '0;
      endcase
   end

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder on the multicycle MIPS shared bus: word RAM plus a 4-register MMIO window.
// Reads are registered at negedge and driven until CS/WE change; writes commit at posedge in one cycle.
module mips_mem_responder
   import mips_mem_responder_pkg::*;
#(
   parameter int          DEPTH     = 128,
   parameter string       INIT_FILE = "mem.dat",
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
)
(
   input  logic                 CLK,
   input  logic                 RST,
   mips_mem_responder_if.slave  bus,
   inout  wire  [31:0]          Mem_Bus,
   input  logic [7:0]           SW,
   output logic [7:0]           LED,
   output logic                 Mem_Err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]   ram [DEPTH];
   logic [31:0]   RData;
   logic [31:0]   readVal;
   logic [31:0]   mmioRData;
   logic [AW-1:0] ramIdx;
   logic [1:0]    mmioOff;
   regionT        region;
   logic          mmioWr;
   logic          errSet;

   assign region  = decodeRegion(bus.Address, 32'(DEPTH), MMIO_BASE);
   assign ramIdx  = bus.Address[AW-1:0];
   assign mmioOff = 2'(bus.Address - MMIO_BASE);
   assign mmioWr  = bus.CS && bus.WE && region == REGION_MMIO;
   assign errSet  = bus.CS && region == REGION_ILLEGAL;

   mips_mmio_regs uMmio (
      .CLK     (CLK),
      .RST     (RST),
      .wrEn    (mmioWr),
      .errSet  (errSet),
      .offset  (mmioOff),
      .wrData  (Mem_Bus[7:0]),
      .SW      (SW),
      .LED     (LED),
      .Mem_Err (Mem_Err),
      .rdData  (mmioRData)
   );

   // RAM contents survive reset; only the write itself is suppressed while RST is high.
   always_ff @(posedge CLK) begin
      if (!RST && bus.CS && bus.WE && region == REGION_RAM)
         ram[ramIdx] <= Mem_Bus;
   end

   always_comb begin
      readVal = '0;
      case (region)
         REGION_RAM:  readVal = ram[ramIdx];
         REGION_MMIO: readVal = mmioRData;
         default:     readVal = '0;
      endcase
   end

   // Negedge capture gives the core a half-cycle of setup before its next posedge.
   always_ff @(negedge CLK or posedge RST) begin
      if (RST)
         RData <= '0;
      else if (bus.CS && !bus.WE)
         RData <= readVal;
   end

   assign Mem_Bus = (bus.CS && !bus.WE && !RST) ? RData : 'z;

endmodule
